// File: rtl/counter.sv
// counter: WIDTH-bit synchronous up-counter with parallel load and count enable.
//   clk      rising-edge clock
//   rst      asynchronous active-low reset; clears cnt_out while low
//   load     parallel-load strobe, takes priority over enab
//   enab     count enable
//   cnt_in   parallel-load data, ignored unless load=1
//   cnt_out  current count, driven directly by the register
// Build option COUNTER_SATURATE_EN: when defined, incrementing at all-ones
// holds all-ones instead of wrapping to zero.
module counter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enab,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] cnt_out
);
   logic [WIDTH-1:0] inc;
`ifdef COUNTER_SATURATE_EN
   assign inc = &cnt_out ? cnt_out : cnt_out + WIDTH'(1);
`else
   assign inc = cnt_out + WIDTH'(1);
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_out <= '0;
      else      cnt_out <= load ? cnt_in : enab ? inc : cnt_out;
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed and randomized checks of counter against an arithmetic reference model.
module tb_counter;
   localparam int W = 5;
   localparam int MAXV = (1 << W) - 1;
`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, load, enab;
   logic [W-1:0] cnt_in, cnt_out, exp_v;
   int vectors = 0;
   int miscompares = 0;

   counter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .load(load), .enab(enab), .cnt_in(cnt_in), .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_next(int cur, bit ld, bit en, int din);
      int n;
      if (ld) n = din;
      else if (!en) n = cur;
      else if (SAT && cur == MAXV) n = MAXV;
      else n = (cur + 1) % (MAXV + 1);
      return W'(n);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; load = 1'b0; enab = 1'b0; cnt_in = '0;
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (cnt_out !== 5'h00) begin miscompares++; $display("FAIL reset_async got=%h exp=%h", cnt_out, 5'h00); end
      load = 1'b1; enab = 1'b1; cnt_in = 5'h1F;
      for (int i = 0; i < 2; i++) begin
         step;
         vectors++;
         if (cnt_out !== 5'h00) begin miscompares++; $display("FAIL reset_hold[%0d] got=%h exp=%h", i, cnt_out, 5'h00); end
      end
      rst = 1'b1;
   endtask

   task automatic test_load_priority;
      logic [W-1:0] v [3];
      v = '{5'h15, 5'h0A, 5'h1F};
      for (int i = 0; i < 3; i++) begin
         load = 1'b1; enab = 1'b1; cnt_in = v[i];
         step;
         vectors++;
         if (cnt_out !== v[i]) begin miscompares++; $display("FAIL load_priority[%0d] got=%h exp=%h", i, cnt_out, v[i]); end
      end
   endtask

   task automatic test_async_reset;
      load = 1'b1; enab = 1'b0; cnt_in = 5'h1F;
      #3 rst = 1'b0;
      #1;
      vectors++;
      if (cnt_out !== 5'h00) begin miscompares++; $display("FAIL async_mid got=%h exp=%h", cnt_out, 5'h00); end
      for (int i = 0; i < 2; i++) begin
         step;
         vectors++;
         if (cnt_out !== 5'h00) begin miscompares++; $display("FAIL async_hold[%0d] got=%h exp=%h", i, cnt_out, 5'h00); end
      end
      rst = 1'b1;
   endtask

   task automatic test_wrap;
      logic [W-1:0] e;
      load = 1'b1; enab = 1'b0; cnt_in = 5'h1F;
      step;
      vectors++;
      if (cnt_out !== 5'h1F) begin miscompares++; $display("FAIL wrap_load got=%h exp=%h", cnt_out, 5'h1F); end
      load = 1'b0; enab = 1'b1;
      e = SAT ? 5'h1F : 5'h00;
      step;
      vectors++;
      if (cnt_out !== e) begin miscompares++; $display("FAIL wrap_inc got=%h exp=%h", cnt_out, e); end
   endtask

   task automatic test_count;
      load = 1'b1; enab = 1'b0; cnt_in = 5'h03;
      step;
      load = 1'b0; enab = 1'b1; cnt_in = 5'h1A;
      for (int i = 0; i < 4; i++) begin
         step;
         vectors++;
         if (cnt_out !== W'(4 + i)) begin miscompares++; $display("FAIL count[%0d] got=%h exp=%h", i, cnt_out, W'(4 + i)); end
      end
   endtask

   task automatic test_hold;
      load = 1'b1; enab = 1'b0; cnt_in = 5'h07;
      step;
      load = 1'b0; cnt_in = 'x;
      for (int i = 0; i < 3; i++) begin
         step;
         vectors++;
         if (cnt_out !== 5'h07) begin miscompares++; $display("FAIL hold[%0d] got=%h exp=%h", i, cnt_out, 5'h07); end
      end
      cnt_in = '0;
   endtask

   task automatic test_release;
      rst = 1'b0; load = 1'b0; enab = 1'b1;
      step;
      rst = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         step;
         vectors++;
         if (cnt_out !== W'(i)) begin miscompares++; $display("FAIL release[%0d] got=%h exp=%h", i, cnt_out, W'(i)); end
      end
   endtask

   task automatic test_random;
      exp_v = cnt_out === 5'h02 ? 5'h02 : 5'h00;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            load = 1'($urandom); enab = 1'($urandom); cnt_in = W'($urandom);
            #2 rst = 1'b0;
            #1;
            exp_v = '0;
            vectors++;
            if (cnt_out !== exp_v) begin miscompares++; $display("FAIL rand_rst[%0d] got=%h exp=%h", i, cnt_out, exp_v); end
            step;
            rst = 1'b1;
         end else begin
            load = ($urandom_range(0, 5) == 0);
            enab = ($urandom_range(0, 3) != 0);
            cnt_in = ($urandom_range(0, 3) == 0) ? W'(MAXV) : W'($urandom);
            exp_v = ref_next(int'(exp_v), load, enab, int'(cnt_in));
            step;
         end
         vectors++;
         if (cnt_out !== exp_v) begin miscompares++; $display("FAIL rand[%0d] got=%h exp=%h", i, cnt_out, exp_v); end
      end
   endtask

   initial begin
      test_reset;
      test_load_priority;
      test_async_reset;
      test_wrap;
      test_count;
      test_hold;
      test_release;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
